// File: rtl/fpalu_pkg.sv
// Shared types for the FP ALU result scoreboard: FSM states, the queued expected-result entry and op encodings.
// The entry match helper is the single definition of pass/fail used by the comparator.
package fpalu_pkg;

    localparam int FP_W  = 32;
    localparam int IDX_W = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [FP_W-1:0]  r;
        logic             ex;
        logic             op;
        logic [IDX_W-1:0] idx;
    } exp_entry_t;

    localparam int ENTRY_W = $bits(exp_entry_t);

    // A raised exception can make the result word meaningless, so mask_r lets it be ignored.
    function automatic logic entry_match(input exp_entry_t e, input logic [FP_W-1:0] r,
                                         input logic ex, input logic mask_r);
        return (ex == e.ex) && ((r == e.r) || (mask_r && e.ex));
    endfunction

endpackage

// File: rtl/fpalu_exp_fifo.sv
// Synchronous FIFO of expected-result entries; read data is the combinational head, write/read take effect next cycle.
// No internal backpressure: a push while full and a pop while empty are dropped, the caller watches full/empty.
module fpalu_exp_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    // The extra pointer bit separates full from empty when the low bits coincide.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fpalu_result_scoreboard.sv
// Aligns reference-model results captured at issue with FP ALU outputs LATENCY cycles later, counts pass/fail, latches first failure.
// Stats update one cycle after the compare; never stalls the ALU, a full FIFO drops the issue and sets overflow.
module fpalu_result_scoreboard
    import fpalu_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16,
    parameter int EX_MASK_R = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              issue_valid,
    input  logic              issue_op,
    input  logic [FP_W-1:0]   exp_r,
    input  logic              exp_ex,
    input  logic [FP_W-1:0]   act_r,
    input  logic              act_ex,
    input  logic              end_of_run,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              first_fail_valid,
    output logic [CNT_W-1:0]  first_fail_index,
    output logic              first_fail_op,
    output logic [FP_W-1:0]   first_fail_act_r,
    output logic [FP_W-1:0]   first_fail_exp_r,
    output logic              overflow,
    output logic              protocol_err
);

    state_e                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [LATENCY-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]      idx_q;
    logic [CNT_W-1:0]      pass_q;
    logic [CNT_W-1:0]      fail_q;
    logic                  ff_vld_q;
    logic [CNT_W-1:0]      ff_idx_q;
    logic                  ff_op_q;
    logic [FP_W-1:0]       ff_act_r_q;
    logic [FP_W-1:0]       ff_exp_r_q;
    logic                  overflow_q;
    logic                  proto_q;

    logic                  in_run;
    logic                  issue_acc;
    logic                  cmp_vld;
    logic                  cmp_match;
    exp_entry_t            entry_in;
    exp_entry_t            head;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [$clog2(DEPTH):0] fifo_count;

    always_comb begin
        in_run    = (state_q == RUN);
        issue_acc = in_run && issue_valid && !fifo_full;
        cmp_vld   = sr_q[LATENCY-1];
        fifo_pop  = cmp_vld && !fifo_empty;
        head      = exp_entry_t'(fifo_rdata);
        cmp_match = entry_match(head, act_r, act_ex, EX_MASK_R != 0);
        // The valid bit only enters with an accepted push, so a popped head always belongs to this compare.
        sr_d      = LATENCY'({sr_q, issue_acc});
        entry_in  = '{r: exp_r, ex: exp_ex, op: issue_op, idx: IDX_W'(idx_q)};
    end

    fpalu_exp_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (issue_acc),
        .wdata_i (entry_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sr_q       <= '0;
            idx_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ff_vld_q   <= 1'b0;
            ff_idx_q   <= '0;
            ff_op_q    <= 1'b0;
            ff_act_r_q <= '0;
            ff_exp_r_q <= '0;
            overflow_q <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            sr_q <= sr_d;

            if (issue_acc) begin
                idx_q <= idx_q + 1'b1;
            end
            if (in_run && issue_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end

            if (cmp_vld) begin
                if (cmp_match) begin
                    if (pass_q != '1) pass_q <= pass_q + 1'b1;
                end else begin
                    if (fail_q != '1) fail_q <= fail_q + 1'b1;
                    if (!ff_vld_q) begin
                        ff_vld_q   <= 1'b1;
                        ff_idx_q   <= CNT_W'(head.idx);
                        ff_op_q    <= head.op;
                        ff_act_r_q <= act_r;
                        ff_exp_r_q <= head.r;
                    end
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        idx_q      <= '0;
                        pass_q     <= '0;
                        fail_q     <= '0;
                        ff_vld_q   <= 1'b0;
                        ff_idx_q   <= '0;
                        ff_op_q    <= 1'b0;
                        ff_act_r_q <= '0;
                        ff_exp_r_q <= '0;
                        overflow_q <= 1'b0;
                        proto_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (end_of_run) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((sr_q == '0) && (fifo_count == '0)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase

            // Placed after the start clear so an illegal issue in the start cycle is still recorded.
            if (issue_valid && !in_run) begin
                proto_q <= 1'b1;
            end
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ff_vld_q;
    assign first_fail_index = ff_idx_q;
    assign first_fail_op    = ff_op_q;
    assign first_fail_act_r = ff_act_r_q;
    assign first_fail_exp_r = ff_exp_r_q;
    assign overflow         = overflow_q;
    assign protocol_err     = proto_q;

endmodule

// File: tb/tb_fpalu_result_scoreboard.sv
// Scoreboard bench for fpalu_result_scoreboard: expected compare outcomes are queued at issue and
// retired whenever the DUT's pass+fail total advances.
module tb_fpalu_result_scoreboard;
    import fpalu_pkg::*;

    localparam int LAT = 3;
    localparam int CW  = 16;
    localparam bit EXM = 1'b1;

    logic          clk;
    logic          reset;
    logic          start;
    logic          issue_valid;
    logic          issue_op;
    logic [31:0]   exp_r;
    logic          exp_ex;
    logic [31:0]   act_r;
    logic          act_ex;
    logic          end_of_run;
    logic          busy;
    logic          done;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] fail_count;
    logic          first_fail_valid;
    logic [CW-1:0] first_fail_index;
    logic          first_fail_op;
    logic [31:0]   first_fail_act_r;
    logic [31:0]   first_fail_exp_r;
    logic          overflow;
    logic          protocol_err;

    fpalu_result_scoreboard #(
        .LATENCY   (LAT),
        .DEPTH     (8),
        .CNT_W     (CW),
        .EX_MASK_R (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .issue_valid      (issue_valid),
        .issue_op         (issue_op),
        .exp_r            (exp_r),
        .exp_ex           (exp_ex),
        .act_r            (act_r),
        .act_ex           (act_ex),
        .end_of_run       (end_of_run),
        .busy             (busy),
        .done             (done),
        .pass_count       (pass_count),
        .fail_count       (fail_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_index (first_fail_index),
        .first_fail_op    (first_fail_op),
        .first_fail_act_r (first_fail_act_r),
        .first_fail_exp_r (first_fail_exp_r),
        .overflow         (overflow),
        .protocol_err     (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          m;
        logic [CW-1:0] idx;
        logic          op;
        logic [31:0]   ar;
        logic [31:0]   er;
        int            due;
    } sb_t;

    sb_t         sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          mdl_pass = 0;
    int          mdl_fail = 0;
    logic        mdl_ff_vld = 1'b0;
    logic [CW-1:0] mdl_ff_idx = '0;
    logic        mdl_ff_op = 1'b0;
    logic [31:0] mdl_ff_ar = '0;
    logic [31:0] mdl_ff_er = '0;
    logic [CW-1:0] mdl_idx = '0;
    bit          sb_run = 1'b0;
    int          max_occ = 0;
    int          prev_tot = 0;
    logic [31:0] ap_r [LAT];
    logic        ap_ex [LAT];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus: act_* replays what was queued LAT steps earlier.
    task automatic step(input logic iv, input logic op, input logic [31:0] er, input logic eex,
                        input logic [31:0] ar, input logic aex, input logic eor, input logic st);
        sb_t e;
        issue_valid = iv;
        issue_op    = op;
        exp_r       = er;
        exp_ex      = eex;
        end_of_run  = eor;
        start       = st;
        act_r       = ap_r[LAT-1];
        act_ex      = ap_ex[LAT-1];
        for (int i = LAT - 1; i > 0; i--) begin
            ap_r[i]  = ap_r[i-1];
            ap_ex[i] = ap_ex[i-1];
        end
        ap_r[0]  = ar;
        ap_ex[0] = aex;
        if (iv && sb_run) begin
            e.m   = (aex == eex) && ((ar == er) || (EXM && eex));
            e.idx = mdl_idx;
            e.op  = op;
            e.ar  = ar;
            e.er  = er;
            e.due = cyc + LAT + 1;
            sb_q.push_back(e);
            mdl_idx++;
        end
        if (eor) sb_run = 1'b0;
        if (st && !sb_run) begin
            sb_run     = 1'b1;
            mdl_pass   = 0;
            mdl_fail   = 0;
            mdl_ff_vld = 1'b0;
            mdl_idx    = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_done(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                at = cyc;
                break;
            end
            idle(1);
        end
        if (at < 0) check(tag, {31'b0, done}, 32'd1);
    endtask

    always @(negedge clk) begin
        int  tot;
        sb_t e;
        tot = int'(pass_count) + int'(fail_count);
        if (int'(dut.u_fifo.count_o) > max_occ) max_occ = int'(dut.u_fifo.count_o);
        if (tot > prev_tot) begin
            if (sb_q.size() == 0) begin
                check("unexp_cmp", tot, prev_tot);
            end else begin
                e = sb_q.pop_front();
                if (e.m) begin
                    mdl_pass++;
                end else begin
                    mdl_fail++;
                    if (!mdl_ff_vld) begin
                        mdl_ff_vld = 1'b1;
                        mdl_ff_idx = e.idx;
                        mdl_ff_op  = e.op;
                        mdl_ff_ar  = e.ar;
                        mdl_ff_er  = e.er;
                    end
                end
                check("cmp_cyc", cyc, e.due);
                check("pass_cnt", pass_count, mdl_pass);
                check("fail_cnt", fail_count, mdl_fail);
            end
        end
        prev_tot = tot;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int at;
        for (int i = 0; i < LAT; i++) begin
            ap_r[i]  = '0;
            ap_ex[i] = 1'b0;
        end
        reset = 1'b1;
        start = 1'b0; issue_valid = 1'b0; issue_op = 1'b0; exp_r = '0; exp_ex = 1'b0;
        act_r = '0; act_ex = 1'b0; end_of_run = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_pass", pass_count, 32'd0);
        check("rst_fail", fail_count, 32'd0);
        check("rst_ffv", {31'b0, first_fail_valid}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        check("rst_perr", {31'b0, protocol_err}, 32'd0);
        idle(1);

        // Single matching add: done exactly LAT+2 cycles after the last issue.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("s1_busy", {31'b0, busy}, 32'd1);
        k = cyc;
        step(1'b1, OP_ADD, 32'h40000000, 1'b0, 32'h40000000, 1'b0, 1'b1, 1'b0);
        wait_done("s1_done_to", at);
        check("s1_done_lat", at - k, LAT + 2);
        check("s1_pass", pass_count, 32'd1);
        check("s1_fail", fail_count, 32'd0);
        check("s1_busy_end", {31'b0, busy}, 32'd0);
        check("s1_ffv", {31'b0, first_fail_valid}, 32'd0);

        // Five issues, indices 2 and 4 mismatch; a start mid-run must be ignored.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] ar;
            ar = (i == 2) ? 32'h40000001 : (i == 4) ? 32'h40000003 : 32'h40000000;
            step(1'b1, (i % 2 == 1) ? OP_MUL : OP_ADD, 32'h40000000, 1'b0, ar, 1'b0,
                 (i == 4), (i == 3));
        end
        wait_done("s2_done_to", at);
        check("s2_pass", pass_count, 32'd3);
        check("s2_fail", fail_count, 32'd2);
        check("s2_ffv", {31'b0, first_fail_valid}, 32'd1);
        check("s2_ff_idx", first_fail_index, 32'd2);
        check("s2_ff_op", {31'b0, first_fail_op}, {31'b0, OP_ADD});
        check("s2_ff_act", first_fail_act_r, 32'h40000001);
        check("s2_ff_exp", first_fail_exp_r, 32'h40000000);
        check("s2_ff_idx_mdl", first_fail_index, mdl_ff_idx);
        check("s2_ff_act_mdl", first_fail_act_r, mdl_ff_ar);

        // Exception-masked result: first passes despite r differing, second fails on ex.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, OP_MUL, 32'h7F800000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0);
        step(1'b1, OP_MUL, 32'h7F800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
        wait_done("s3_done_to", at);
        check("s3_pass", pass_count, 32'd1);
        check("s3_fail", fail_count, 32'd1);
        check("s3_ff_idx", first_fail_index, 32'd1);
        check("s3_ff_op", {31'b0, first_fail_op}, {31'b0, OP_MUL});

        // Twenty back-to-back muls.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        max_occ = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, OP_MUL, 32'h3F800000 + i, 1'b0, 32'h3F800000 + i, 1'b0, (i == 19), 1'b0);
        end
        wait_done("s4_done_to", at);
        check("s4_pass", pass_count, 32'd20);
        check("s4_fail", fail_count, 32'd0);
        check("s4_ovf", {31'b0, overflow}, 32'd0);
        check("s4_max_occ", max_occ, LAT);
        check("s4_sb_empty", sb_q.size(), 32'd0);

        // Reset mid-run: nothing in flight may ever be compared.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, OP_ADD, 32'h12340000 + i, 1'b0, 32'hDEAD0000 + i, 1'b1, 1'b0, 1'b0);
        end
        reset = 1'b1;
        sb_q.delete();
        sb_run = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        check("s5_busy", {31'b0, busy}, 32'd0);
        check("s5_done", {31'b0, done}, 32'd0);
        check("s5_pass", pass_count, 32'd0);
        check("s5_fail", fail_count, 32'd0);
        check("s5_ffv", {31'b0, first_fail_valid}, 32'd0);
        check("s5_ovf", {31'b0, overflow}, 32'd0);
        check("s5_perr", {31'b0, protocol_err}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, (i % 2 == 0) ? 32'hFFFFFFFF : 32'h0, i[0], 1'b0, 1'b0);
        end
        check("s5_pass_late", pass_count, 32'd0);
        check("s5_fail_late", fail_count, 32'd0);
        check("s5_busy_late", {31'b0, busy}, 32'd0);

        // Issue while IDLE is flagged, never compared; the next start clears it.
        step(1'b1, OP_ADD, 32'h40000000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("s6_perr", {31'b0, protocol_err}, 32'd1);
        idle(5);
        check("s6_pass", pass_count, 32'd0);
        check("s6_fail", fail_count, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("s6_perr_clr", {31'b0, protocol_err}, 32'd0);
        check("s6_busy", {31'b0, busy}, 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        wait_done("s6_done_to", at);
        check("s6_done", {31'b0, done}, 32'd1);
        check("s6_sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpalu_result_scoreboard.md
Name: fpalu_result_scoreboard

Overview:
- Sits directly downstream of the FP ALU (topdut) and its reference model.
- Aligns the expected result/exception from the reference model, captured at issue time, with the pipelined DUT output LATENCY cycles later.
- Compares the two, counts pass/fail, and latches the first failure.
- Replaces manual post-run array comparison with a self-checking, synthesizable stage.

Parameters:
- LATENCY, 3, DUT cycles from operand issue to result on act_r/act_ex (1..DEPTH-1).
- DEPTH, 8, expected-entry FIFO depth; power of 2; must be >= LATENCY+1.
- CNT_W, 16, width of issue index and pass/fail counters.
- EX_MASK_R, 1, when 1 and exp_ex=1, only the exception bit is compared (result is don't-care).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: clear stats and begin a run (honoured in IDLE or DONE).
- issue_valid  in  1  an operand pair entered the DUT this cycle.
- issue_op  in  1  operation select s at issue (0 add, 1 mul).
- exp_r  in  32  reference-model result for this issue.
- exp_ex  in  1  reference-model exception for this issue.
- act_r  in  32  DUT result.
- act_ex  in  1  DUT exception.
- end_of_run  in  1  last issue is this cycle or earlier; begin drain.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  all issued entries compared; held until start or reset.
- pass_count  out  CNT_W  matching compares, saturating.
- fail_count  out  CNT_W  mismatching compares, saturating.
- first_fail_valid  out  1  a failure has been latched this run.
- first_fail_index  out  CNT_W  issue index of the first failure.
- first_fail_op  out  1  issue_op of the first failure.
- first_fail_act_r  out  32  act_r of the first failure.
- first_fail_exp_r  out  32  exp_r of the first failure.
- overflow  out  1  sticky: issue dropped because FIFO was full.
- protocol_err  out  1  sticky: issue_valid seen outside RUN.

Behaviour:
- Reset:
  - Every output is 0, FSM is IDLE, FIFO is empty, the valid shift register is cleared, and the issue index is 0.
  - Reset mid-run discards all in-flight entries; results arriving later are never compared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start goes to RUN and clears counters, first_fail_*, overflow, protocol_err, issue index and done.
  - RUN + end_of_run goes to DRAIN. An issue_valid in the same cycle is accepted as the last entry.
  - DRAIN goes to DONE in the first cycle where the shift register is all-zero and the FIFO is empty. done=1 from the next cycle onward.
  - start in RUN/DRAIN is ignored.
- Issue (RUN and issue_valid):
  - Push {exp_r, exp_ex, issue_op, index} into the FIFO.
  - Shift a 1 into the LATENCY-deep valid shift register; the index increments and wraps at 2^CNT_W.
  - If the FIFO is full: no push, no shift-in, overflow<=1.
- issue_valid in IDLE/DRAIN/DONE: ignored, protocol_err<=1.
- Compare, in cycle T+LATENCY for an issue at cycle T, when the shift register's output bit is 1:
  - Pop the FIFO head.
  - match = (act_ex==head.ex) && (act_r==head.r || (EX_MASK_R && head.ex)).
  - Counters update at T+LATENCY+1 and saturate at all-ones.
  - On the first mismatch of the run, first_fail_* are latched (also at T+LATENCY+1). Later mismatches never overwrite them.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- Plain bitwise compare: NaN payloads, ±0 and rounding are not special-cased. The reference model defines correctness.
- With legal use (DEPTH >= LATENCY+1, at most one issue per cycle), the FIFO never overflows.
- Minimum done latency: last issue at T gives done=1 at T+LATENCY+2.

Decomposition:
- Package fpalu_pkg holds:
  - FP_W=32;
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - the packed exp_entry_t {r[31:0], ex, op, idx[CNT_W-1:0]};
  - op encodings OP_ADD=0, OP_MUL=1.
- One sub-module, fpalu_exp_fifo: synchronous FIFO, DEPTH x width(exp_entry_t), with full/empty flags and wrapping pointers plus an extra wrap bit.
- The top level holds the FSM, shift register, comparator, counters and first-fail latch.

Test Plan:
- LATENCY=3, start, one add issue exp_r=40000000 exp_ex=0; at T+3 act_r=40000000 act_ex=0 -> pass_count=1, fail_count=0, done=1 at T+5, busy=0.
- 5 issues, index 2 gets act_r=40000001 vs exp 40000000; index 4 also mismatches -> fail_count=2, pass_count=3, first_fail_index=2, first_fail_act_r=40000001, first_fail_exp_r=40000000.
- exp_ex=1 exp_r=7F800000, act_ex=1 act_r=00000000 with EX_MASK_R=1 -> pass_count=1. Same with act_ex=0 -> fail_count=1.
- 20 back-to-back mul issues, all matching, end_of_run with the 20th -> pass_count=20, overflow=0, FIFO occupancy never exceeds 4.
- Reset asserted 2 cycles after 3 issues, then act_r toggles with no further issues -> all outputs 0 and FSM IDLE the cycle after reset; counters stay 0.
- issue_valid=1 while IDLE -> protocol_err=1, pass/fail counts 0; next start clears protocol_err.
